// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sizing constants and batch-loader state encoding for the sort datapath
package sort_pkg;

  localparam int ELEM_W = 32;
  localparam int NUM_ELEM = 32;
  localparam logic [ELEM_W-1:0] PAD_VALUE = '1;
  localparam int CNT_W = $clog2(NUM_ELEM + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/sort_batch_loader.sv
// rtl/sort_batch_loader.sv - packs a valid/ready element stream into the sorter input vector
// Short batches are padded with a maximal sentinel; the vector is held until the sorter reports done.
module sort_batch_loader
  import sort_pkg::*;
#(
  parameter int ELEM_W = sort_pkg::ELEM_W,
  parameter int NUM_ELEM = sort_pkg::NUM_ELEM,
  parameter logic [ELEM_W-1:0] PAD_VALUE = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [ELEM_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         start_sort,
  input  logic                         done_sort,
  output logic [NUM_ELEM*ELEM_W-1:0]   batch_data,
  output logic [$clog2(NUM_ELEM+1)-1:0] batch_count,
  output logic                         busy
);

  localparam int CW = $clog2(NUM_ELEM + 1);
  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q;
  logic [CW-1:0]              count_q;
  logic                       start_q;
  logic [NUM_ELEM*ELEM_W-1:0] data_q;
  logic [NUM_ELEM-1:0]        slot_en;
  logic                       hs;
  logic                       last_slot;
  logic                       wr_any;
  logic [ELEM_W-1:0]          wr_val;

  // Gated by rst so upstream never sees ready while the loader is held in reset.
  assign s_ready     = (state_q == FILL) && !rst;
  assign busy        = (state_q != FILL);
  assign hs          = s_valid && s_ready;
  assign last_slot   = (idx_q == IDX_W'(NUM_ELEM - 1));
  assign wr_any      = hs || (state_q == PAD);
  assign wr_val      = (state_q == PAD) ? PAD_VALUE : s_data;
  assign start_sort  = start_q;
  assign batch_data  = data_q;
  assign batch_count = count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (hs) begin
          if (last_slot) begin
            state_d = LAUNCH;
          end else if (s_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (last_slot) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (done_sort) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    slot_en = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      slot_en[k] = wr_any && (idx_q == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == LAUNCH);
      // idx wraps to 0 on the final slot, so it is already cleared when the next batch starts.
      if (wr_any) begin
        idx_q <= last_slot ? '0 : idx_q + 1'b1;
      end
      if (hs) begin
        count_q <= (idx_q == '0) ? CW'(1) : count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        if (slot_en[k]) begin
          data_q[k*ELEM_W +: ELEM_W] <= wr_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_batch_loader.sv
// tb/tb_sort_batch_loader.sv - self-checking bench for sort_batch_loader
module tb_sort_batch_loader;
  import sort_pkg::*;

  localparam int W = ELEM_W;
  localparam int N = NUM_ELEM;
  localparam int CW = $clog2(N + 1);
  localparam logic [W-1:0] PADV = '1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic           done_sort = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic           s_ready;
  logic           start_sort;
  logic           busy;
  logic [N*W-1:0] batch_data;
  logic [CW-1:0]  batch_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sort_batch_loader dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .start_sort(start_sort),
    .done_sort(done_sort),
    .batch_data(batch_data),
    .batch_count(batch_count),
    .busy(busy)
  );

  // Behavioural model: batch contents are filled in whole when a batch closes,
  // and the launch is a countdown of (pad slots + 1) cycles from the closing handshake.
  logic [W-1:0] m_slot [N];
  bit m_accept;
  bit m_wait;
  int m_n;
  int m_count;
  int m_cd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_slot[i] = '0;
      m_accept = 1'b1;
      m_wait = 1'b0;
      m_n = 0;
      m_count = 0;
      m_cd = 0;
    end else if (m_accept) begin
      if (s_valid) begin
        m_slot[m_n] = s_data;
        m_n++;
        m_count = m_n;
        if (m_n == N || s_last) begin
          for (int i = m_n; i < N; i++) m_slot[i] = PADV;
          m_cd = N - m_n + 1;
          m_accept = 1'b0;
          m_n = 0;
        end
      end
    end else if (m_wait) begin
      if (done_sort) begin
        m_wait = 1'b0;
        m_accept = 1'b1;
      end
    end else if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) m_wait = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model_data();
    logic [N*W-1:0] e;
    int first;
    for (int i = 0; i < N; i++) e[i*W +: W] = m_slot[i];
    total++;
    if (batch_data !== e) begin
      bad++;
      first = 0;
      for (int i = N - 1; i >= 0; i--) if (batch_data[i*W +: W] !== e[i*W +: W]) first = i;
      $display("FAIL batch_data slot %0d: got %0h expected %0h at %0t",
               first, batch_data[first*W +: W], e[first*W +: W], $time);
    end
  endtask

  task automatic chk_slot(input int k, input logic [W-1:0] exp);
    chk($sformatf("slot%0d", k), 64'(batch_data[k*W +: W]), 64'(exp));
  endtask

  always @(negedge clk) begin
    chk("mon_s_ready", 64'(s_ready), 64'(!rst && m_accept));
    chk("mon_busy", 64'(busy), 64'(!rst && !m_accept));
    chk("mon_start_sort", 64'(start_sort), 64'(!rst && m_cd == 1 && !m_wait));
    chk("mon_batch_count", 64'(batch_count), 64'(m_count));
    if (rst || m_cd <= 1) chk_model_data();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    bit took;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    took = 1'b0;
    for (int i = 0; i < 200 && !took; i++) begin
      took = s_ready;
      step();
    end
    chk("send_handshake", 64'(took), 64'd1);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    cyc = 1;
    while (!start_sort && cyc < 300) begin
      step();
      cyc++;
    end
    chk("start_seen", 64'(start_sort), 64'd1);
  endtask

  task automatic release_batch();
    repeat (3) step();
    chk("ready_low_in_wait", 64'(s_ready), 64'd0);
    done_sort = 1'b1;
    step();
    done_sort = 1'b0;
    chk("ready_after_done", 64'(s_ready), 64'd1);
  endtask

  int lat;

  initial begin
    step();
    chk("reset_ready", 64'(s_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 64'(s_ready), 64'd1);
    chk("post_reset_count", 64'(batch_count), 64'd0);
    chk("post_reset_data", 64'(batch_data[63:0]), 64'd0);

    // Full batch of 31..0
    for (int k = 0; k < N; k++) send(W'(N - 1 - k), 1'b0);
    idle();
    wait_start(lat);
    chk("full_latency", 64'(lat), 64'd1);
    chk("full_count", 64'(batch_count), 64'd32);
    for (int k = 0; k < N; k++) chk_slot(k, W'(31 - k));
    release_batch();

    // Short batch {7,3,9,1,4}
    send(7, 1'b0); send(3, 1'b0); send(9, 1'b0); send(1, 1'b0); send(4, 1'b1);
    idle();
    chk("short_count", 64'(batch_count), 64'd5);
    wait_start(lat);
    chk("short_latency", 64'(lat), 64'd28);
    chk_slot(0, 7); chk_slot(1, 3); chk_slot(2, 9); chk_slot(3, 1); chk_slot(4, 4);
    chk_slot(5, 32'hFFFF_FFFF); chk_slot(31, 32'hFFFF_FFFF);
    release_batch();

    // Single element
    send(32'h10, 1'b1);
    idle();
    wait_start(lat);
    chk("single_latency", 64'(lat), 64'd32);
    chk("single_count", 64'(batch_count), 64'd1);
    chk_slot(0, 32'h10); chk_slot(1, 32'hFFFF_FFFF); chk_slot(31, 32'hFFFF_FFFF);
    release_batch();

    // Overlong stream: 40 elements, s_last only on the 40th
    for (int k = 0; k < N; k++) send(W'(100 + k), 1'b0);
    s_valid = 1'b1;
    s_data = 132;
    s_last = 1'b0;
    repeat (6) step();
    chk("overlong_stall", 64'(s_ready), 64'd0);
    chk_slot(31, 131);
    done_sort = 1'b1;
    step();
    done_sort = 1'b0;
    for (int k = 32; k < 40; k++) send(W'(100 + k), k == 39);
    idle();
    chk("overlong_count", 64'(batch_count), 64'd8);
    wait_start(lat);
    chk("overlong_latency", 64'(lat), 64'd25);
    chk_slot(0, 132); chk_slot(7, 139); chk_slot(8, 32'hFFFF_FFFF);
    release_batch();

    // done_sort held high through FILL, PAD and LAUNCH
    done_sort = 1'b1;
    send(6, 1'b0); send(2, 1'b1);
    idle();
    wait_start(lat);
    chk("early_latency", 64'(lat), 64'd31);
    step();
    done_sort = 1'b0;
    repeat (8) step();
    chk("early_busy", 64'(busy), 64'd1);
    chk("early_ready", 64'(s_ready), 64'd0);
    chk_slot(0, 6); chk_slot(1, 2); chk_slot(2, 32'hFFFF_FFFF);
    release_batch();

    // Reset in the middle of PAD
    send(11, 1'b0); send(22, 1'b0); send(33, 1'b1);
    idle();
    step(); step();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 64'(batch_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(start_sort), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_data_lo", 64'(batch_data[63:0]), 64'd0);
    chk("rst_data_hi", 64'(batch_data[N*W-1 -: 64]), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(s_ready), 64'd1);
    send(44, 1'b0); send(55, 1'b1);
    idle();
    chk("post_rst_count", 64'(batch_count), 64'd2);
    chk_slot(0, 44); chk_slot(1, 55);
    wait_start(lat);
    chk("post_rst_latency", 64'(lat), 64'd31);
    release_batch();

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
